// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage that drives a req/ack data bus and registers MEM/WB.
// Ports:
//   in_clk, in_rst        clock; asynchronous active-high reset
//   in_dmem_*             EX/MEM memory control (enable, store, access type)
//   in_rt_data            store data
//   in_alu_result         effective address or ALU result
//   in_rd_*               writeback destination, source select, enable
//   out_bus_*, in_bus_*   req/ack data-memory bus
//   out_stall             hold EX/MEM and earlier stages
//   out_wb_*              MEM/WB register
//   out_misalign          one-cycle pulse on a suppressed misaligned access
module mem_access_stage #(
   parameter int ADDR_W = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_dmem_ena,
   input  logic              in_dmem_wena,
   input  logic [1:0]        in_dmem_type,
   input  logic [31:0]       in_rt_data,
   input  logic [31:0]       in_alu_result,
   input  logic [4:0]        in_rd_waddr,
   input  logic              in_rd_sel,
   input  logic              in_rd_wena,
   output logic              out_bus_req,
   output logic              out_bus_we,
   output logic [ADDR_W-1:0] out_bus_addr,
   output logic [3:0]        out_bus_be,
   output logic [31:0]       out_bus_wdata,
   input  logic              in_bus_ack,
   input  logic [31:0]       in_bus_rdata,
   output logic              out_stall,
   output logic [31:0]       out_wb_data,
   output logic [4:0]        out_wb_waddr,
   output logic              out_wb_wena,
   output logic              out_misalign
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic mis, go, sel_q, wena_q;
   logic [1:0] type_q, a_q;
   logic [3:0] be_c;
   logic [4:0] waddr_q;
   logic [31:0] wdata_c, alu_q, rdata_q, sh, ext;
   always_comb begin
      mis = ALIGN_CHECK && (in_dmem_type == 2'b00 ? in_alu_result[1:0] != 2'b00
                          : in_dmem_type == 2'b01 && in_alu_result[0]);
      go = in_dmem_ena && !mis;
      be_c = in_dmem_type == 2'b00 ? 4'b1111
           : in_dmem_type == 2'b01 ? 4'b0011 << in_alu_result[1:0]
           : 4'b0001 << in_alu_result[1:0];
      wdata_c = in_dmem_type == 2'b00 ? in_rt_data
              : in_dmem_type == 2'b01 ? {2{in_rt_data[15:0]}}
              : {4{in_rt_data[7:0]}};
      state_nxt = state == IDLE ? (go ? BUSY : IDLE)
                : state == BUSY ? (in_bus_ack ? DONE : BUSY)
                : IDLE;
      out_stall = state == BUSY || (state == IDLE && go);
      // move the addressed lane down to bit 0 before extension
      sh = rdata_q >> {a_q, 3'b000};
      ext = type_q == 2'b00 ? rdata_q
          : type_q == 2'b01 ? {{16{sh[15]}}, sh[15:0]}
          : type_q == 2'b10 ? {{24{sh[7]}}, sh[7:0]}
          : {24'd0, sh[7:0]};
   end
   always_ff @(posedge in_clk or posedge in_rst)
      if (in_rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge in_clk or posedge in_rst)
      if (in_rst) begin
         out_bus_req <= 1'b0;
         out_bus_we <= 1'b0;
         out_bus_addr <= '0;
         out_bus_be <= 4'd0;
         out_bus_wdata <= 32'd0;
         out_wb_data <= 32'd0;
         out_wb_waddr <= 5'd0;
         out_wb_wena <= 1'b0;
         out_misalign <= 1'b0;
         type_q <= 2'd0;
         a_q <= 2'd0;
         sel_q <= 1'b0;
         wena_q <= 1'b0;
         waddr_q <= 5'd0;
         alu_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         out_misalign <= 1'b0;
         case (state)
            IDLE: begin
               out_wb_data <= in_alu_result;
               out_wb_waddr <= in_rd_waddr;
               // any memory access (started or suppressed) leaves a bubble here
               out_wb_wena <= in_rd_wena && !in_dmem_ena;
               out_misalign <= in_dmem_ena && mis;
               if (go) begin
                  out_bus_req <= 1'b1;
                  out_bus_we <= in_dmem_wena;
                  out_bus_addr <= {in_alu_result[ADDR_W-1:2], 2'b00};
                  out_bus_be <= be_c;
                  out_bus_wdata <= wdata_c;
                  type_q <= in_dmem_type;
                  a_q <= in_alu_result[1:0];
                  sel_q <= in_rd_sel;
                  wena_q <= in_rd_wena;
                  waddr_q <= in_rd_waddr;
                  alu_q <= in_alu_result;
               end
            end
            BUSY: begin
               out_wb_wena <= 1'b0;
               if (in_bus_ack) begin
                  out_bus_req <= 1'b0;
                  rdata_q <= in_bus_rdata;
               end
            end
            DONE: begin
               out_wb_data <= (!out_bus_we && sel_q) ? ext : alu_q;
               out_wb_waddr <= waddr_q;
               out_wb_wena <= wena_q;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
   logic in_clk = 1'b0, in_rst = 1'b1;
   logic in_dmem_ena = 0, in_dmem_wena = 0, in_rd_sel = 0, in_rd_wena = 0, in_bus_ack = 0;
   logic [1:0] in_dmem_type = 0;
   logic [31:0] in_rt_data = 0, in_alu_result = 0, in_bus_rdata = 0;
   logic [4:0] in_rd_waddr = 0;
   logic req, we, stall, wb_wena, misal;
   logic [31:0] addr, wdata, wb_data;
   logic [3:0] be;
   logic [4:0] wb_waddr;
   logic req0, we0, stall0, wb_wena0, misal0;
   logic [31:0] addr0, wdata0, wb_data0;
   logic [3:0] be0;
   logic [4:0] wb_waddr0;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0] cap_be;
   logic cap_we, cap_req;
   int checks = 0, failures = 0;
   always #5 in_clk = ~in_clk;
   mem_access_stage #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena),
      .in_dmem_type(in_dmem_type), .in_rt_data(in_rt_data), .in_alu_result(in_alu_result),
      .in_rd_waddr(in_rd_waddr), .in_rd_sel(in_rd_sel), .in_rd_wena(in_rd_wena),
      .out_bus_req(req), .out_bus_we(we), .out_bus_addr(addr), .out_bus_be(be),
      .out_bus_wdata(wdata), .in_bus_ack(in_bus_ack), .in_bus_rdata(in_bus_rdata),
      .out_stall(stall), .out_wb_data(wb_data), .out_wb_waddr(wb_waddr),
      .out_wb_wena(wb_wena), .out_misalign(misal));
   mem_access_stage #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) dut0 (
      .in_clk(in_clk), .in_rst(in_rst), .in_dmem_ena(in_dmem_ena), .in_dmem_wena(in_dmem_wena),
      .in_dmem_type(in_dmem_type), .in_rt_data(in_rt_data), .in_alu_result(in_alu_result),
      .in_rd_waddr(in_rd_waddr), .in_rd_sel(in_rd_sel), .in_rd_wena(in_rd_wena),
      .out_bus_req(req0), .out_bus_we(we0), .out_bus_addr(addr0), .out_bus_be(be0),
      .out_bus_wdata(wdata0), .in_bus_ack(in_bus_ack), .in_bus_rdata(in_bus_rdata),
      .out_stall(stall0), .out_wb_data(wb_data0), .out_wb_waddr(wb_waddr0),
      .out_wb_wena(wb_wena0), .out_misalign(misal0));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge in_clk);
      #1;
   endtask
   // one access acked in its first BUSY cycle; returns one cycle after DONE
   task automatic run_access(input logic w, input logic [1:0] ty, input logic [31:0] a,
                             input logic [31:0] rt, input logic [31:0] rd,
                             input logic sel, input logic wen, input logic [4:0] wa);
      in_dmem_ena = 1; in_dmem_wena = w; in_dmem_type = ty; in_alu_result = a;
      in_rt_data = rt; in_rd_sel = sel; in_rd_wena = wen; in_rd_waddr = wa;
      tick;
      cap_addr = addr; cap_be = be; cap_wdata = wdata; cap_we = we; cap_req = req;
      in_bus_ack = 1; in_bus_rdata = rd;
      tick;
      in_bus_ack = 0; in_dmem_ena = 0; in_rd_wena = 0;
      tick;
   endtask
   initial begin
      #3;
      chk("rst_req", {31'd0, req}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_wena", {31'd0, wb_wena}, 0);
      tick; tick;
      in_rst = 0;
      in_alu_result = 32'h1234; in_rd_waddr = 5; in_rd_wena = 1;
      #1 chk("alu_stall", {31'd0, stall}, 0);
      tick;
      chk("alu_wb_data", wb_data, 32'h1234);
      chk("alu_wb_waddr", {27'd0, wb_waddr}, 5);
      chk("alu_wb_wena", {31'd0, wb_wena}, 1);
      chk("alu_req", {31'd0, req}, 0);
      in_dmem_ena = 1; in_dmem_wena = 0; in_dmem_type = 0; in_alu_result = 32'h100;
      in_rd_sel = 1; in_rd_wena = 1; in_rd_waddr = 7;
      #1 chk("lw_idle_stall", {31'd0, stall}, 1);
      chk("lw_idle_req", {31'd0, req}, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         if (i == 2) begin in_bus_ack = 1; in_bus_rdata = 32'hDEADBEEF; end
         chk("lw_busy_req", {31'd0, req}, 1);
         chk("lw_busy_stall", {31'd0, stall}, 1);
         chk("lw_busy_addr", addr, 32'h100);
         chk("lw_busy_be", {28'd0, be}, 4'hF);
         chk("lw_busy_wb_wena", {31'd0, wb_wena}, 0);
      end
      tick;
      in_bus_ack = 0; in_dmem_ena = 0; in_rd_wena = 0;
      chk("lw_done_req", {31'd0, req}, 0);
      chk("lw_done_stall", {31'd0, stall}, 0);
      chk("lw_done_wb_wena", {31'd0, wb_wena}, 0);
      tick;
      chk("lw_wb_data", wb_data, 32'hDEADBEEF);
      chk("lw_wb_wena", {31'd0, wb_wena}, 1);
      chk("lw_wb_waddr", {27'd0, wb_waddr}, 7);
      run_access(1, 2'b10, 32'h103, 32'hA5, 32'h0, 0, 0, 3);
      chk("sb_be", {28'd0, cap_be}, 4'b1000);
      chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
      chk("sb_we", {31'd0, cap_we}, 1);
      chk("sb_req", {31'd0, cap_req}, 1);
      chk("sb_wb_wena", {31'd0, wb_wena}, 0);
      run_access(1, 2'b01, 32'h102, 32'h1234BEEF, 32'h0, 0, 0, 3);
      chk("sh_be", {28'd0, cap_be}, 4'b1100);
      chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
      run_access(0, 2'b01, 32'h102, 32'h0, 32'h80FF0000, 1, 1, 9);
      chk("lh_wb_data", wb_data, 32'hFFFF80FF);
      chk("lh_wb_wena", {31'd0, wb_wena}, 1);
      chk("lh_wb_waddr", {27'd0, wb_waddr}, 9);
      run_access(0, 2'b10, 32'h102, 32'h0, 32'h80FF0000, 1, 1, 10);
      chk("lb_wb_data", wb_data, 32'hFFFFFFFF);
      run_access(0, 2'b11, 32'h103, 32'h0, 32'h80FF0000, 1, 1, 11);
      chk("lbu_wb_data", wb_data, 32'h00000080);
      chk("lbu_addr", cap_addr, 32'h100);
      in_dmem_ena = 1; in_dmem_wena = 0; in_dmem_type = 0; in_alu_result = 32'h101;
      in_rd_sel = 1; in_rd_wena = 1; in_rd_waddr = 4;
      #1 chk("mis_stall", {31'd0, stall}, 0);
      chk("mis0_stall", {31'd0, stall0}, 1);
      tick;
      in_dmem_ena = 0; in_rd_wena = 0; in_bus_ack = 1; in_bus_rdata = 32'h0;
      chk("mis_pulse", {31'd0, misal}, 1);
      chk("mis_req", {31'd0, req}, 0);
      chk("mis_wb_wena", {31'd0, wb_wena}, 0);
      chk("mis0_req", {31'd0, req0}, 1);
      chk("mis0_addr", addr0, 32'h100);
      tick;
      in_bus_ack = 0;
      chk("mis_pulse_end", {31'd0, misal}, 0);
      chk("mis0_done_req", {31'd0, req0}, 0);
      tick;
      in_dmem_ena = 1; in_dmem_type = 0; in_alu_result = 32'h200; in_rd_wena = 1;
      tick;
      chk("rstmid_req_pre", {31'd0, req}, 1);
      in_dmem_ena = 0; in_rd_wena = 0;
      #2 in_rst = 1;
      #1 chk("rstmid_req", {31'd0, req}, 0);
      chk("rstmid_stall", {31'd0, stall}, 0);
      chk("rstmid_wb_wena", {31'd0, wb_wena}, 0);
      chk("rstmid_addr", addr, 0);
      tick;
      in_rst = 0; in_bus_ack = 1; in_bus_rdata = 32'h55;
      tick;
      in_bus_ack = 0;
      chk("late_ack_req", {31'd0, req}, 0);
      chk("late_ack_wb_wena", {31'd0, wb_wena}, 0);
      tick;
      chk("late_ack_wb_wena2", {31'd0, wb_wena}, 0);
      chk("late_ack_stall", {31'd0, stall}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
